// File: rtl/adxl345_spi_burst_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adxl345_spi_burst_master : SPI mode-3 register burst engine (cmd + 1..MAX_BYTES)
// Revision 1.0
// ---------------------------------------------------------------------------
module adxl345_spi_burst_master #(
  parameter  int CLK_DIV   = 50,
  parameter  int MAX_BYTES = 6,
  parameter  int CS_GAP    = 8,
  localparam int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rw,
  input  logic [5:0]             addr,
  input  logic [NB_W-1:0]        nbytes,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   spi_clk,
  output logic                   cs,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int TXW = 8 * (MAX_BYTES + 1);
  localparam int BW  = $clog2(TXW);
  localparam int IW  = BW - 3;
  localparam int DW  = $clog2(CLK_DIV);
  localparam int GW  = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [NB_W-1:0] NB_MAX   = NB_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [DW-1:0]            cnt_q, cnt_d;
  logic                     half_q, half_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic [BW-1:0]            last_bit_q, last_bit_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic                     rw_q, rw_d;
  logic [TXW-1:0]           tx_q, tx_d;
  logic [7:0]               rx_q, rx_d;
  logic                     rd_byte_q, rd_byte_d;
  logic [IW-1:0]            byte_idx_q, byte_idx_d;
  logic                     cs_q, cs_d;
  logic                     spi_clk_q, spi_clk_d;
  logic                     mosi_q, mosi_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     byte_valid_q, byte_valid_d;
  logic [7:0]               byte_data_q, byte_data_d;
  logic [8*MAX_BYTES-1:0]   rdata_q, rdata_d;

  logic w_req_ok;
  logic w_fall;
  logic w_rise;

  assign w_req_ok = (nbytes != '0) && (nbytes <= NB_MAX);
  // Every output is registered from the current state, so pins trail the FSM by one clk.
  assign w_fall   = (state_q == ST_SHIFT) && (cnt_q == '0) && !half_q;
  assign w_rise   = (state_q == ST_SHIFT) && (cnt_q == '0) &&  half_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    bit_d        = bit_q;
    last_bit_d   = last_bit_q;
    gap_d        = gap_q;
    rw_d         = rw_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rd_byte_d    = 1'b0;
    byte_idx_d   = byte_idx_q;
    rdata_d      = rdata_q;
    spi_clk_d    = spi_clk_q;
    mosi_d       = mosi_q;
    error_d      = 1'b0;
    cs_d         = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
    busy_d       = (state_q != ST_IDLE);
    done_d       = (state_q == ST_GAP) && (gap_q == '0);
    byte_valid_d = rd_byte_q;
    byte_data_d  = rd_byte_q ? rx_q : byte_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (w_req_ok) begin
            state_d    = ST_SETUP;
            cnt_d      = '0;
            rw_d       = rw;
            last_bit_d = BW'({nbytes, 3'b111});
            tx_d       = '0;
            tx_d[TXW-1 -: 8] = {rw, (nbytes > NB_W'(1)), addr};
            if (!rw) begin
              for (int k = 0; k < MAX_BYTES; k++) begin
                tx_d[TXW-9-8*k -: 8] = wdata[8*k +: 8];
              end
            end else begin
              rdata_d = '0;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          half_d = !half_q;
          if (half_q) begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (w_fall) begin
          spi_clk_d = 1'b0;
          mosi_d    = tx_q[TXW-1];
          tx_d      = {tx_q[TXW-2:0], 1'b0};
        end
        if (w_rise) begin
          spi_clk_d = 1'b1;
          rx_d      = {rx_q[6:0], miso};
          if (rw_q && (bit_q[2:0] == 3'b111) && (bit_q[BW-1:3] != '0)) begin
            rd_byte_d  = 1'b1;
            byte_idx_d = bit_q[BW-1:3] - IW'(1);
          end
          // The rise cycle itself counts as the first HOLD cycle.
          if (bit_q == last_bit_q) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        mosi_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rd_byte_q) begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (byte_idx_q == IW'(k)) begin
          rdata_d[8*k +: 8] = rx_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      half_q       <= 1'b0;
      bit_q        <= '0;
      last_bit_q   <= '0;
      gap_q        <= '0;
      rw_q         <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      rd_byte_q    <= 1'b0;
      byte_idx_q   <= '0;
      rdata_q      <= '0;
      cs_q         <= 1'b1;
      spi_clk_q    <= 1'b1;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      last_bit_q   <= last_bit_d;
      gap_q        <= gap_d;
      rw_q         <= rw_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rd_byte_q    <= rd_byte_d;
      byte_idx_q   <= byte_idx_d;
      rdata_q      <= rdata_d;
      cs_q         <= cs_d;
      spi_clk_q    <= spi_clk_d;
      mosi_q       <= mosi_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign rdata      = rdata_q;
  assign spi_clk    = spi_clk_q;
  assign cs         = cs_q;
  assign mosi       = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_adxl345_spi_burst_master.sv
`default_nettype none
// Bench: directed and randomized frames against a behavioural frame/timing model
// with a mode-3 ADXL345-style register slave.
module tb_adxl345_spi_burst_master;

  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 6;
  localparam int CS_GAP    = 8;
  localparam int NB_W      = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [5:0]  addr = '0;
  logic [NB_W-1:0] nbytes = '0;
  logic [47:0] wdata = '0;
  logic        busy, done, error, byte_valid;
  logic [7:0]  byte_data;
  logic [47:0] rdata;
  logic        spi_clk, cs, mosi;
  logic        miso;

  adxl345_spi_burst_master #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BYTES(MAX_BYTES),
    .CS_GAP   (CS_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rw        (rw),
    .addr      (addr),
    .nbytes    (nbytes),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .rdata     (rdata),
    .spi_clk   (spi_clk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edge monitor: en is the index of the most recent rising clk edge.
  int en = 0;
  int cs_fall_e = -1, cs_fall_n = 0, done_e = -1, done_n = 0;
  int busy_fall_e = -1, busy_rise_n = 0, err_n = 0, rises = 0;
  logic [7:0] bv_data[$];
  int         bv_e[$];
  logic p_cs = 1'b1, p_sclk = 1'b1, p_busy = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    en++;
    if (p_cs && !cs) begin cs_fall_e = en; cs_fall_n++; end
    if (done) begin done_e = en; done_n++; end
    if (p_busy && !busy) busy_fall_e = en;
    if (!p_busy && busy) busy_rise_n++;
    if (error) err_n++;
    if (byte_valid) begin bv_data.push_back(byte_data); bv_e.push_back(en); end
    if (!p_sclk && spi_clk && !cs) rises++;
    p_cs = cs; p_sclk = spi_clk; p_busy = busy;
  end

  // Mode-3 register slave: shifts out on SCLK fall, samples on SCLK rise.
  logic [7:0] mem[64];
  logic [7:0] cap[$];
  logic [7:0] s_sh = '0, s_cmd = '0;
  int         s_bit = 0;
  logic       pc = 1'b1, ps = 1'b1;

  function automatic logic [5:0] slave_addr(input int k);
    return 6'(int'(s_cmd[5:0]) + (s_cmd[6] ? k : 0));
  endfunction

  initial begin
    miso = 1'b0;
    forever begin
      @(cs or spi_clk);
      if (pc && !cs) begin
        s_bit = 0;
        cap.delete();
      end else if (!cs && !ps && spi_clk) begin
        s_sh = {s_sh[6:0], mosi};
        s_bit++;
        if (s_bit % 8 == 0) begin
          cap.push_back(s_sh);
          if (s_bit == 8) s_cmd = s_sh;
          else if (!s_cmd[7]) mem[slave_addr(s_bit / 8 - 2)] = s_sh;
        end
      end else if (!cs && ps && !spi_clk) begin
        miso = (s_bit >= 8 && s_cmd[7]) ? mem[slave_addr(s_bit / 8 - 1)][7 - (s_bit % 8)] : 1'b0;
      end
      pc = cs;
      ps = spi_clk;
    end
  end

  logic [47:0] exp_rdata = '0;

  // Issue one request, then check the whole frame against the reference timing/data.
  task automatic run_frame(input logic r, input logic [5:0] a, input int nb,
                           input logic [47:0] wd, input int collide_at);
    int e0, n, d0, dn0, f0;
    logic [63:0] exp_st, got_st;
    logic [7:0]  eb[$];
    exp_st = 64'({r, (nb > 1), a});
    if (r) exp_rdata = '0;
    for (int k = 0; k < nb; k++) begin
      logic [7:0] b;
      b = mem[6'(int'(a) + (nb > 1 ? k : 0))];
      exp_st = {exp_st[55:0], (r ? 8'h00 : wd[8*k +: 8])};
      if (r) begin
        eb.push_back(b);
        exp_rdata[8*k +: 8] = b;
      end
    end
    bv_data.delete(); bv_e.delete();
    rises = 0; dn0 = done_n; f0 = cs_fall_n;
    @(negedge clk);
    rw = r; addr = a; nbytes = NB_W'(nb); wdata = wd; start = 1'b1;
    e0 = en + 1;
    @(negedge clk);
    start = 1'b0;
    rw = 1'($urandom); addr = 6'($urandom); nbytes = NB_W'(1 + $urandom_range(0, 5));
    wdata = {16'($urandom), 32'($urandom)};
    if (collide_at > 0) begin
      while (en < e0 + collide_at - 1) @(en);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && !(busy_fall_e > e0); i++) @(negedge clk);
    check_val("timeout", 64'(busy_fall_e > e0), 64'd1);
    repeat (12) @(negedge clk);
    n  = 8 * (nb + 1);
    d0 = e0 + 1 + (2 * n + 1) * CLK_DIV;
    check_val("cs_fall_edge", 64'(cs_fall_e), 64'(e0 + 1));
    check_val("one_frame", 64'(cs_fall_n - f0), 64'd1);
    check_val("sclk_rises", 64'(rises), 64'(n));
    check_val("done_edge", 64'(done_e), 64'(d0));
    check_val("done_count", 64'(done_n - dn0), 64'd1);
    check_val("busy_fall_edge", 64'(busy_fall_e), 64'(d0 + CS_GAP));
    got_st = '0;
    for (int i = 0; i < cap.size(); i++) got_st = {got_st[55:0], cap[i]};
    check_val("mosi_stream", got_st, exp_st);
    check_val("byte_valid_count", 64'(bv_data.size()), 64'(r ? nb : 0));
    for (int k = 0; k < bv_data.size() && k < eb.size(); k++) begin
      check_val("byte_data", 64'(bv_data[k]), 64'(eb[k]));
      check_val("byte_valid_edge", 64'(bv_e[k]), 64'(e0 + 2 + 16 * (k + 2) * CLK_DIV));
    end
    check_val("rdata", 64'(rdata), 64'(exp_rdata));
  endtask

  initial begin
    int e0, d1, f1, dn, en0, fe0;
    #900000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int e, f, br, dn, d1, f1, e0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE5;
    for (int k = 0; k < 6; k++) mem[6'h32 + k] = 8'(8'h11 * (k + 1));

    repeat (3) @(negedge clk);
    check_val("rst_cs", 64'(cs), 64'd1);
    check_val("rst_sclk", 64'(spi_clk), 64'd1);
    check_val("rst_outs", 64'({mosi, busy, done, error, byte_valid}), 64'd0);
    check_val("rst_data", 64'({byte_data, rdata}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed frames
    run_frame(1'b0, 6'h2D, 1, 48'h08, 0);
    check_val("powerctl_mem", 64'(mem[6'h2D]), 64'h08);
    run_frame(1'b1, 6'h00, 1, 48'h0, 0);
    check_val("devid", 64'(rdata[7:0]), 64'hE5);
    run_frame(1'b1, 6'h32, 6, 48'h0, 40);
    check_val("burst_rdata", 64'(rdata), 64'h665544332211);
    check_val("burst_last_byte", 64'(byte_data), 64'h66);

    // Rejected requests
    e = err_n; f = cs_fall_n; br = busy_rise_n;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      rw = 1'b1; nbytes = (t == 0) ? 3'd0 : 3'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check_val("reject_error", 64'(err_n - e), 64'(t + 1));
    end
    check_val("reject_no_cs", 64'(cs_fall_n - f), 64'd0);
    check_val("reject_no_busy", 64'(busy_rise_n - br), 64'd0);

    // Back-to-back with start held high
    dn = done_n;
    @(negedge clk);
    rw = 1'b0; addr = 6'h1E; nbytes = 3'd1; wdata = 48'h5A; start = 1'b1;
    for (int i = 0; i < 2000 && done_n == dn; i++) @(negedge clk);
    d1 = done_e; f1 = cs_fall_n;
    for (int i = 0; i < 100 && cs_fall_n == f1; i++) @(negedge clk);
    start = 1'b0;
    check_val("b2b_cs_fall", 64'(cs_fall_e), 64'(d1 + CS_GAP + 1));
    for (int i = 0; i < 2000 && done_n < dn + 2; i++) @(negedge clk);
    check_val("b2b_done_count", 64'(done_n - dn), 64'd2);
    repeat (12) @(negedge clk);
    check_val("b2b_mem", 64'(mem[6'h1E]), 64'h5A);

    // Reset in the middle of a write frame
    dn = done_n;
    @(negedge clk);
    rw = 1'b0; addr = 6'h20; nbytes = 3'd6; wdata = 48'hA1A2A3A4A5A6; start = 1'b1;
    e0 = en + 1;
    @(negedge clk);
    start = 1'b0;
    while (en < e0 + 60) @(en);
    rst = 1'b1;
    #1;
    check_val("midrst_cs", 64'(cs), 64'd1);
    check_val("midrst_sclk", 64'(spi_clk), 64'd1);
    check_val("midrst_rdata", 64'(rdata), 64'd0);
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_val("midrst_no_done", 64'(done_n - dn), 64'd0);
    run_frame(1'b1, 6'h32, 6, 48'h0, 0);

    // Randomized requests
    for (int i = 0; i < 10; i++) begin
      run_frame(1'($urandom), 6'($urandom), 1 + $urandom_range(0, 5),
                {16'($urandom), 32'($urandom)}, (i % 3 == 0) ? 30 + $urandom_range(0, 20) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
